// File: rtl/ram8_arbiter_pkg.sv
// rtl/ram8_arbiter_pkg.sv - state and owner encodings shared by the RAM8 arbiter files
package ram8_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/arb2_rr.sv
// rtl/arb2_rr.sv - combinational 2-way grant, round-robin or fixed A priority
// Optional feature macro: RAM8_ARB_FIXED_PRIO_EN (A always wins ties; last_i ignored)
module arb2_rr
  import ram8_arbiter_pkg::*;
(
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic last_i,
  output logic valid_o,
  output logic owner_o
);

`ifdef RAM8_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

  always_comb begin
    valid_o = req_a_i | req_b_i;
    owner_o = OWN_A;
    if (req_a_i && req_b_i) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
      owner_o = OWN_A;
`else
      owner_o = ~last_i;
`endif
    end else if (req_b_i) begin
      owner_o = OWN_B;
    end
  end

endmodule

// File: rtl/ram8_arbiter.sv
// rtl/ram8_arbiter.sv - two-requester access controller for one RAM8 (IDLE/ACCESS/DONE sequencer)
// Optional feature macro: RAM8_ARB_FIXED_PRIO_EN (handled inside arb2_rr)
module ram8_arbiter
  import ram8_arbiter_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              done_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_out
);

  state_e              state_q;
  logic                owner_q;
  logic                last_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                load_q;
  logic                gnt_a_q, gnt_b_q, done_a_q, done_b_q;
  logic [DATA_W-1:0]   rdata_a_q, rdata_b_q;

  logic                win_valid;
  logic                win_owner;
  logic                we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;

  arb2_rr u_arb (
    .req_a_i (req_a),
    .req_b_i (req_b),
    .last_i  (last_q),
    .valid_o (win_valid),
    .owner_o (win_owner)
  );

  always_comb begin
    we_d    = (win_owner == OWN_B) ? we_b    : we_a;
    addr_d  = (win_owner == OWN_B) ? addr_b  : addr_a;
    wdata_d = (win_owner == OWN_B) ? wdata_b : wdata_a;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      last_q    <= OWN_B;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      load_q    <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      load_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            owner_q <= win_owner;
            last_q  <= win_owner;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= we_d;
            gnt_a_q <= (win_owner == OWN_A);
            gnt_b_q <= (win_owner == OWN_B);
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // RAM8 read is combinational, so ram_out is valid for addr_q by this edge
          if (!we_q && owner_q == OWN_A) rdata_a_q <= ram_out;
          if (!we_q && owner_q == OWN_B) rdata_b_q <= ram_out;
          done_a_q <= (owner_q == OWN_A);
          done_b_q <= (owner_q == OWN_B);
          state_q  <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reset gates load directly so a write caught mid-ACCESS never commits
  assign ram_load = load_q & ~reset;
  assign ram_addr = addr_q;
  assign ram_in   = wdata_q;
  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign done_a   = done_a_q;
  assign done_b   = done_b_q;
  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// tb/tb_ram8_arbiter.sv - table-driven and randomized self-checking bench for ram8_arbiter
module tb_ram8_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [2:0]  addr_a, addr_b, ram_addr;
  logic [15:0] wdata_a, wdata_b, rdata_a, rdata_b, ram_in, ram_out;
  logic        gnt_a, gnt_b, done_a, done_b, ram_load;

  int vectors = 0;
  int miscompares = 0;

  ram8_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .done_a(done_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .done_b(done_b), .rdata_b(rdata_b),
    .ram_in(ram_in), .ram_load(ram_load), .ram_addr(ram_addr), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // RAM8 stand-in: synchronous write, combinational read
  logic [15:0] ram [8];
  always @(posedge clk) if (ram_load) ram[ram_addr] <= ram_in;
  assign ram_out = ram[ram_addr];

  // Reference model state
  logic [15:0] mem_m [8];
  logic        last_m;
  logic [15:0] rd_a_m, rd_b_m;

  typedef struct {
    logic        ra; logic wa; logic [2:0] aa; logic [15:0] da;
    logic        rb; logic wb; logic [2:0] ab; logic [15:0] db;
    logic        eo;
    logic [15:0] er;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic pick(input logic ra, input logic rb, input logic last);
    if (ra && rb) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return !last;
`endif
    end
    return rb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle in IDLE; leaves one cycle in IDLE again.
  task automatic run_round(input vec_t v);
    logic        w;
    logic [2:0]  a;
    logic [15:0] d;
    req_a = v.ra; we_a = v.wa; addr_a = v.aa; wdata_a = v.da;
    req_b = v.rb; we_b = v.wb; addr_b = v.ab; wdata_b = v.db;
    w = v.eo ? v.wb : v.wa;
    a = v.eo ? v.ab : v.aa;
    d = v.eo ? v.db : v.da;
    tick();
    chk("gnt_a", gnt_a, !v.eo);
    chk("gnt_b", gnt_b, v.eo);
    chk("ram_load", ram_load, w);
    chk("ram_addr", ram_addr, a);
    chk("ram_in", ram_in, d);
    if (v.eo) req_b = 1'b0; else req_a = 1'b0;
    tick();
    if (w) mem_m[a] = d;
    else if (v.eo) rd_b_m = v.er;
    else rd_a_m = v.er;
    last_m = v.eo;
    chk("done_a", done_a, !v.eo);
    chk("done_b", done_b, v.eo);
    chk("load_in_done", ram_load, 1'b0);
    chk("rdata_a", rdata_a, rd_a_m);
    chk("rdata_b", rdata_b, rd_b_m);
    tick();
  endtask

  function automatic vec_t mk(input logic ra, input logic wa, input logic [2:0] aa, input logic [15:0] da,
                              input logic rb, input logic wb, input logic [2:0] ab, input logic [15:0] db,
                              input logic eo, input logic [15:0] er);
    vec_t v;
    v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb; v.wb = wb; v.ab = ab; v.db = db;
    v.eo = eo; v.er = er;
    return v;
  endfunction

  initial begin
    vec_t        v;
    logic        pa, pb, wa, wb;
    logic [2:0]  aa, ab;
    logic [15:0] da, db;

    for (int i = 0; i < 8; i++) begin ram[i] = '0; mem_m[i] = '0; end
    last_m = 1'b1; rd_a_m = '0; rd_b_m = '0;
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    chk("rst_done", {done_a, done_b}, 2'b00);
    chk("rst_load", ram_load, 1'b0);
    chk("rst_addr", ram_addr, 3'd0);
    chk("rst_in", ram_in, 16'h0);
    chk("rst_rdata", {rdata_a, rdata_b}, 32'h0);

    tbl.push_back(mk(1, 1, 3'd3, 16'h1234, 0, 0, 3'd0, 16'h0, 1'b0, 16'h0));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0, 1, 0, 3'd3, 16'h0, 1'b1, 16'h1234));
    tbl.push_back(mk(1, 0, 3'd3, 16'h0, 1, 0, 3'd3, 16'h0, 1'b0, 16'h1234));
`ifdef RAM8_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 0, 3'd3, 16'h0, 1, 0, 3'd3, 16'h0, 1'b0, 16'h1234));
`else
    tbl.push_back(mk(1, 0, 3'd3, 16'h0, 1, 0, 3'd3, 16'h0, 1'b1, 16'h1234));
`endif
    tbl.push_back(mk(1, 0, 3'd3, 16'h0, 1, 0, 3'd3, 16'h0, 1'b0, 16'h1234));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1, 1, 3'(i), 16'(i * 16'h1000), 0, 0, 3'd0, 16'h0, 1'b0, 16'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 3'd0, 16'h0, 1, 0, 3'(i), 16'h0, 1'b1, 16'(i * 16'h1000)));
    tbl.push_back(mk(0, 0, 3'd0, 16'h0, 1, 0, 3'd0, 16'h0, 1'b1, 16'h0000));

    foreach (tbl[i]) run_round(tbl[i]);

    // Reset lands while an A write of BEEF to address 5 is in ACCESS
    req_a = 1; we_a = 1; addr_a = 3'd5; wdata_a = 16'hBEEF;
    tick();
    chk("abort_gnt_a", gnt_a, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_load_gated", ram_load, 1'b0);
    req_a = 0; we_a = 0;
    tick();
    reset = 1'b0;
    last_m = 1'b1; rd_a_m = '0; rd_b_m = '0;
    chk("abort_done", {done_a, done_b}, 2'b00);
    chk("abort_rdata", {rdata_a, rdata_b}, 32'h0);
    tick();
    chk("abort_no_late_done", {done_a, done_b}, 2'b00);
    run_round(mk(0, 0, 3'd0, 16'h0, 1, 0, 3'd5, 16'h0, 1'b1, 16'h5000));

    for (int i = 0; i < 10; i++) begin
      chk("idle_quiet", {gnt_a, gnt_b, done_a, done_b, ram_load}, 5'b0);
      tick();
    end

    // Random traffic; a losing request stays pending with the same command
    pa = 0; pb = 0; wa = 0; wb = 0; aa = 0; ab = 0; da = 0; db = 0;
    for (int n = 0; n < 60; n++) begin
      if (!pa && ($urandom_range(0, 9) < 6)) begin
        pa = 1; wa = 1'($urandom); aa = 3'($urandom); da = 16'($urandom);
      end
      if (!pb && ($urandom_range(0, 9) < 6)) begin
        pb = 1; wb = 1'($urandom); ab = 3'($urandom); db = 16'($urandom);
      end
      if (!pa && !pb) begin
        pa = 1; wa = 1'($urandom); aa = 3'($urandom); da = 16'($urandom);
      end
      v = mk(pa, wa, aa, da, pb, wb, ab, db, 1'b0, 16'h0);
      v.eo = pick(pa, pb, last_m);
      v.er = mem_m[v.eo ? ab : aa];
      run_round(v);
      if (v.eo) pb = 0; else pa = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
